// File: rtl/reorder_buffer_pkg.sv
// Shared core constants for the rename/retire slice.
package reorder_buffer_pkg;

    localparam int RRF_NUM  = 64;  // ROB/RRF entries, power of two
    localparam int RRF_SEL  = 6;   // log2(RRF_NUM), tag width
    localparam int REG_SEL  = 5;   // architectural register index width
    localparam int DATA_LEN = 32;  // datapath width used elsewhere in the core

endpackage

// File: rtl/rob_commit_select.sv
// Combinational retire selection: up to two in-order commits from the head.
module rob_commit_select
    import reorder_buffer_pkg::*;
(
    input  logic [RRF_SEL-1:0] comptr_i,
    input  logic [RRF_NUM-1:0] valid_i,
    input  logic [RRF_NUM-1:0] finished_i,
    input  logic [RRF_NUM-1:0] dst_we_i,
    input  logic [REG_SEL-1:0] dstnum_i [RRF_NUM],
    output logic               c1_o,
    output logic               c2_o,
    output logic [1:0]         com_inst_num_o,
    output logic               com1_we_o,
    output logic [REG_SEL-1:0] com1_dstnum_o,
    output logic [RRF_SEL-1:0] com1_rrftag_o,
    output logic               com2_we_o,
    output logic [REG_SEL-1:0] com2_dstnum_o,
    output logic [RRF_SEL-1:0] com2_rrftag_o
);

    logic [RRF_SEL-1:0] ptr2;

    // Second retire slot is the entry after the head; tag width wraps it.
    assign ptr2 = comptr_i + RRF_SEL'(1);

    // Select retiring entries and mux their write-back fields.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        c1_o           = 1'b0;
        c2_o           = 1'b0;
        com1_we_o      = 1'b0;
        com1_dstnum_o  = '0;
        com1_rrftag_o  = '0;
        com2_we_o      = 1'b0;
        com2_dstnum_o  = '0;
        com2_rrftag_o  = '0;

        c1_o = valid_i[comptr_i] & finished_i[comptr_i];
        c2_o = c1_o & valid_i[ptr2] & finished_i[ptr2];

        if (c1_o) begin
            com1_we_o     = dst_we_i[comptr_i];
            com1_dstnum_o = dstnum_i[comptr_i];
            com1_rrftag_o = comptr_i;
        end
        if (c2_o) begin
            com2_we_o     = dst_we_i[ptr2];
            com2_dstnum_o = dstnum_i[ptr2];
            com2_rrftag_o = ptr2;
        end
        com_inst_num_o = {1'b0, c1_o} + {1'b0, c2_o};
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer indexed by RRF tag; retires up to two per cycle.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               stall_dp_i,
    input  logic               dp1_i,
    input  logic [RRF_SEL-1:0] dp1_rrftag_i,
    input  logic [REG_SEL-1:0] dp1_dstnum_i,
    input  logic               dp1_dst_we_i,
    input  logic               dp2_i,
    input  logic [RRF_SEL-1:0] dp2_rrftag_i,
    input  logic [REG_SEL-1:0] dp2_dstnum_i,
    input  logic               dp2_dst_we_i,
    input  logic               fin_alu1_i,
    input  logic [RRF_SEL-1:0] fin_alu1_rrftag_i,
    input  logic               fin_alu2_i,
    input  logic [RRF_SEL-1:0] fin_alu2_rrftag_i,
    input  logic               fin_ldst_i,
    input  logic [RRF_SEL-1:0] fin_ldst_rrftag_i,
    input  logic               fin_mul_i,
    input  logic [RRF_SEL-1:0] fin_mul_rrftag_i,
    input  logic               fin_branch_i,
    input  logic [RRF_SEL-1:0] fin_branch_rrftag_i,
    output logic [RRF_SEL-1:0] comptr_o,
    output logic [1:0]         com_inst_num_o,
    output logic               com1_we_o,
    output logic [REG_SEL-1:0] com1_dstnum_o,
    output logic [RRF_SEL-1:0] com1_rrftag_o,
    output logic               com2_we_o,
    output logic [REG_SEL-1:0] com2_dstnum_o,
    output logic [RRF_SEL-1:0] com2_rrftag_o,
    output logic               empty_o
);

    logic [RRF_NUM-1:0] valid_q, valid_d;
    logic [RRF_NUM-1:0] finished_q, finished_d;
    logic [RRF_NUM-1:0] dst_we_q, dst_we_d;
    logic [REG_SEL-1:0] dstnum_q [RRF_NUM];
    logic [REG_SEL-1:0] dstnum_d [RRF_NUM];
    logic [RRF_SEL-1:0] comptr_q, comptr_d;

    logic               c1, c2;
    logic [4:0]         fin_v;
    logic [RRF_SEL-1:0] fin_tag [5];
    logic               acc1, acc2;

    assign fin_v   = {fin_branch_i, fin_mul_i, fin_ldst_i, fin_alu2_i, fin_alu1_i};
    assign fin_tag = '{fin_alu1_rrftag_i, fin_alu2_rrftag_i, fin_ldst_rrftag_i,
                       fin_mul_rrftag_i, fin_branch_rrftag_i};

    // Slot 2 is only ever accepted alongside slot 1.
    assign acc1 = !stall_dp_i && dp1_i;
    assign acc2 = acc1 && dp2_i;

    rob_commit_select u_commit (
        .comptr_i       (comptr_q),
        .valid_i        (valid_q),
        .finished_i     (finished_q),
        .dst_we_i       (dst_we_q),
        .dstnum_i       (dstnum_q),
        .c1_o           (c1),
        .c2_o           (c2),
        .com_inst_num_o (com_inst_num_o),
        .com1_we_o      (com1_we_o),
        .com1_dstnum_o  (com1_dstnum_o),
        .com1_rrftag_o  (com1_rrftag_o),
        .com2_we_o      (com2_we_o),
        .com2_dstnum_o  (com2_dstnum_o),
        .com2_rrftag_o  (com2_rrftag_o)
    );

    // Next state: retire clears, then dispatch allocates, then finishes mark done.
    always_comb begin
        valid_d    = valid_q;
        finished_d = finished_q;
        dst_we_d   = dst_we_q;
        dstnum_d   = dstnum_q;
        comptr_d   = comptr_q + RRF_SEL'(com_inst_num_o);

        if (c1) begin
            valid_d[comptr_q]    = 1'b0;
            finished_d[comptr_q] = 1'b0;
        end
        if (c2) begin
            valid_d[comptr_q + RRF_SEL'(1)]    = 1'b0;
            finished_d[comptr_q + RRF_SEL'(1)] = 1'b0;
        end

        if (acc1) begin
            valid_d[dp1_rrftag_i]    = 1'b1;
            finished_d[dp1_rrftag_i] = 1'b0;
            dst_we_d[dp1_rrftag_i]   = dp1_dst_we_i;
            dstnum_d[dp1_rrftag_i]   = dp1_dstnum_i;
        end
        if (acc2) begin
            valid_d[dp2_rrftag_i]    = 1'b1;
            finished_d[dp2_rrftag_i] = 1'b0;
            dst_we_d[dp2_rrftag_i]   = dp2_dst_we_i;
            dstnum_d[dp2_rrftag_i]   = dp2_dstnum_i;
        end

        // Applied last so a finish overrides a same-tag dispatch; invalid tags are ignored.
        for (int i = 0; i < 5; i++) begin
            if (fin_v[i] && valid_d[fin_tag[i]]) begin
                finished_d[fin_tag[i]] = 1'b1;
            end
        end
    end

    // Control state: valid/finished bits and the head pointer.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_q    <= '0;
            finished_q <= '0;
            comptr_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            valid_q    <= valid_d;
            finished_q <= finished_d;
            comptr_q   <= comptr_d;
        end
    end

    // Entry payload storage.
    // NOTE: payload is left unreset; it is only read behind a set valid bit.
    always_ff @(posedge clk_i) begin
        dst_we_q <= dst_we_d;
        dstnum_q <= dstnum_d;
    end

    assign comptr_o = comptr_q;
    assign empty_o  = ~|valid_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed, scoreboard-based bench for reorder_buffer.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    typedef struct packed {
        logic               we;
        logic [REG_SEL-1:0] dst;
        logic [RRF_SEL-1:0] tag;
    } exp_t;

    logic               clk_i = 1'b0;
    logic               reset_i;
    logic               stall_dp_i;
    logic               dp1_i, dp1_dst_we_i, dp2_i, dp2_dst_we_i;
    logic [RRF_SEL-1:0] dp1_rrftag_i, dp2_rrftag_i;
    logic [REG_SEL-1:0] dp1_dstnum_i, dp2_dstnum_i;
    logic               fin_alu1_i, fin_alu2_i, fin_ldst_i, fin_mul_i, fin_branch_i;
    logic [RRF_SEL-1:0] fin_alu1_rrftag_i, fin_alu2_rrftag_i, fin_ldst_rrftag_i;
    logic [RRF_SEL-1:0] fin_mul_rrftag_i, fin_branch_rrftag_i;
    logic [RRF_SEL-1:0] comptr_o;
    logic [1:0]         com_inst_num_o;
    logic               com1_we_o, com2_we_o, empty_o;
    logic [REG_SEL-1:0] com1_dstnum_o, com2_dstnum_o;
    logic [RRF_SEL-1:0] com1_rrftag_o, com2_rrftag_o;

    int   checks = 0;
    int   errors = 0;
    exp_t sb [$];

    reorder_buffer dut (
        .clk_i(clk_i), .reset_i(reset_i), .stall_dp_i(stall_dp_i),
        .dp1_i(dp1_i), .dp1_rrftag_i(dp1_rrftag_i), .dp1_dstnum_i(dp1_dstnum_i),
        .dp1_dst_we_i(dp1_dst_we_i),
        .dp2_i(dp2_i), .dp2_rrftag_i(dp2_rrftag_i), .dp2_dstnum_i(dp2_dstnum_i),
        .dp2_dst_we_i(dp2_dst_we_i),
        .fin_alu1_i(fin_alu1_i), .fin_alu1_rrftag_i(fin_alu1_rrftag_i),
        .fin_alu2_i(fin_alu2_i), .fin_alu2_rrftag_i(fin_alu2_rrftag_i),
        .fin_ldst_i(fin_ldst_i), .fin_ldst_rrftag_i(fin_ldst_rrftag_i),
        .fin_mul_i(fin_mul_i), .fin_mul_rrftag_i(fin_mul_rrftag_i),
        .fin_branch_i(fin_branch_i), .fin_branch_rrftag_i(fin_branch_rrftag_i),
        .comptr_o(comptr_o), .com_inst_num_o(com_inst_num_o),
        .com1_we_o(com1_we_o), .com1_dstnum_o(com1_dstnum_o), .com1_rrftag_o(com1_rrftag_o),
        .com2_we_o(com2_we_o), .com2_dstnum_o(com2_dstnum_o), .com2_rrftag_o(com2_rrftag_o),
        .empty_o(empty_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pop the scoreboard for every slot the DUT retires this cycle.
    task automatic mon();
        exp_t e;
        if (com_inst_num_o >= 2'd1) begin
            if (sb.size() == 0) check("sb_empty_on_commit", 32'(com_inst_num_o), 32'd0);
            else begin
                e = sb.pop_front();
                check("com1_we", 32'(com1_we_o), 32'(e.we));
                check("com1_dstnum", 32'(com1_dstnum_o), 32'(e.dst));
                check("com1_rrftag", 32'(com1_rrftag_o), 32'(e.tag));
            end
        end else begin
            check("idle_com1_we", 32'(com1_we_o), 32'd0);
        end
        if (com_inst_num_o == 2'd2) begin
            if (sb.size() == 0) check("sb_empty_on_commit2", 32'(com_inst_num_o), 32'd0);
            else begin
                e = sb.pop_front();
                check("com2_we", 32'(com2_we_o), 32'(e.we));
                check("com2_dstnum", 32'(com2_dstnum_o), 32'(e.dst));
                check("com2_rrftag", 32'(com2_rrftag_o), 32'(e.tag));
            end
        end
    endtask

    task automatic clear_strobes();
        dp1_i = 0; dp2_i = 0;
        fin_alu1_i = 0; fin_alu2_i = 0; fin_ldst_i = 0; fin_mul_i = 0; fin_branch_i = 0;
    endtask

    task automatic tick();
        mon();
        @(posedge clk_i);
        #1;
        clear_strobes();
    endtask

    task automatic dp1(input logic [5:0] tag, input logic [4:0] dst, input logic we);
        dp1_i = 1; dp1_rrftag_i = tag; dp1_dstnum_i = dst; dp1_dst_we_i = we;
        sb.push_back('{we: we, dst: dst, tag: tag});
    endtask

    task automatic dp2(input logic [5:0] tag, input logic [4:0] dst, input logic we);
        dp2_i = 1; dp2_rrftag_i = tag; dp2_dstnum_i = dst; dp2_dst_we_i = we;
        sb.push_back('{we: we, dst: dst, tag: tag});
    endtask

    task automatic fin(input int unit, input logic [5:0] tag);
        case (unit)
            0: begin fin_alu1_i = 1;   fin_alu1_rrftag_i = tag;   end
            1: begin fin_alu2_i = 1;   fin_alu2_rrftag_i = tag;   end
            2: begin fin_ldst_i = 1;   fin_ldst_rrftag_i = tag;   end
            3: begin fin_mul_i = 1;    fin_mul_rrftag_i = tag;    end
            default: begin fin_branch_i = 1; fin_branch_rrftag_i = tag; end
        endcase
    endtask

    initial begin
        reset_i = 1; stall_dp_i = 0;
        dp1_rrftag_i = '0; dp1_dstnum_i = '0; dp1_dst_we_i = 0;
        dp2_rrftag_i = '0; dp2_dstnum_i = '0; dp2_dst_we_i = 0;
        fin_alu1_rrftag_i = '0; fin_alu2_rrftag_i = '0; fin_ldst_rrftag_i = '0;
        fin_mul_rrftag_i = '0; fin_branch_rrftag_i = '0;
        clear_strobes();

        // Reset state
        #12;
        check("rst_comptr", 32'(comptr_o), 32'd0);
        check("rst_empty", 32'(empty_o), 32'd1);
        check("rst_num", 32'(com_inst_num_o), 32'd0);
        #1 reset_i = 0;

        // Reset during activity: fill tags 0-5 with 0,1 finished
        dp1(0, 5'd1, 1); dp2(1, 5'd2, 1); tick();
        dp1(2, 5'd3, 1); dp2(3, 5'd4, 1); tick();
        dp1(4, 5'd5, 1); dp2(5, 5'd6, 1); fin(0, 0); fin(1, 1); tick();
        check("pre_rst_num", 32'(com_inst_num_o), 32'd2);
        #2 reset_i = 1;
        #1;
        check("midrst_num", 32'(com_inst_num_o), 32'd0);
        check("midrst_com1_we", 32'(com1_we_o), 32'd0);
        check("midrst_comptr", 32'(comptr_o), 32'd0);
        check("midrst_empty", 32'(empty_o), 32'd1);
        sb.delete();
        @(posedge clk_i); @(posedge clk_i);
        #3 reset_i = 0;
        tick(); tick(); tick();
        check("postrst_num", 32'(com_inst_num_o), 32'd0);
        check("postrst_comptr", 32'(comptr_o), 32'd0);
        check("postrst_empty", 32'(empty_o), 32'd1);

        // Dual dispatch, out-of-order finish
        dp1(0, 5'd3, 1); dp2(1, 5'd4, 1); tick();
        check("dp_not_empty", 32'(empty_o), 32'd0);
        fin(1, 1); tick();
        check("wait_head_num", 32'(com_inst_num_o), 32'd0);
        fin(0, 0); tick();
        check("dual_num", 32'(com_inst_num_o), 32'd2);
        check("dual_comptr_before", 32'(comptr_o), 32'd0);
        tick();
        check("dual_comptr_after", 32'(comptr_o), 32'd2);
        check("dual_empty", 32'(empty_o), 32'd1);

        // Single retire with dst_we=0
        dp1(2, 5'd7, 0); tick();
        fin(3, 2); tick();
        check("single_num", 32'(com_inst_num_o), 32'd1);
        check("single_we", 32'(com1_we_o), 32'd0);
        check("single_tag", 32'(com1_rrftag_o), 32'd2);
        check("single_c2_dst_zero", 32'(com2_dstnum_o), 32'd0);
        check("single_c2_tag_zero", 32'(com2_rrftag_o), 32'd0);
        tick();
        check("single_comptr", 32'(comptr_o), 32'd3);

        // Advance head to 63
        for (int t = 3; t < 63; t += 2) begin
            dp1(6'(t), 5'(t), 1'(t)); dp2(6'(t + 1), 5'(t + 1), 1'(t + 1)); tick();
            fin(0, 6'(t)); fin(1, 6'(t + 1)); tick();
        end
        tick();
        check("pre_wrap_comptr", 32'(comptr_o), 32'd63);

        // Wrap-around pair 63 / 0
        dp1(63, 5'd9, 1); dp2(0, 5'd10, 1); tick();
        fin(2, 63); fin(4, 0); tick();
        check("wrap_num", 32'(com_inst_num_o), 32'd2);
        check("wrap_tag1", 32'(com1_rrftag_o), 32'd63);
        check("wrap_tag2", 32'(com2_rrftag_o), 32'd0);
        tick();
        check("wrap_comptr", 32'(comptr_o), 32'd1);

        // Advance head to 10 with single dispatches
        for (int t = 1; t < 10; t++) begin
            dp1(6'(t), 5'(t + 7), 1'(t)); tick();
            fin(4, 6'(t)); tick();
        end
        tick();
        check("pre5_comptr", 32'(comptr_o), 32'd10);

        // Five simultaneous finishes on tags 10-14
        dp1(10, 5'd20, 1); dp2(11, 5'd21, 0); tick();
        dp1(12, 5'd22, 1); dp2(13, 5'd23, 1); tick();
        dp1(14, 5'd24, 1); tick();
        fin(0, 10); fin(1, 11); fin(2, 12); fin(3, 13); fin(4, 14); tick();
        check("f5_num_a", 32'(com_inst_num_o), 32'd2);
        check("f5_comptr_a", 32'(comptr_o), 32'd10);
        tick();
        check("f5_num_b", 32'(com_inst_num_o), 32'd2);
        check("f5_comptr_b", 32'(comptr_o), 32'd12);
        tick();
        check("f5_num_c", 32'(com_inst_num_o), 32'd1);
        check("f5_comptr_c", 32'(comptr_o), 32'd14);
        tick();
        check("f5_comptr_end", 32'(comptr_o), 32'd15);
        check("f5_num_end", 32'(com_inst_num_o), 32'd0);

        // Finish to an invalid entry is dropped
        fin(0, 16); tick();
        dp1(15, 5'd25, 1); dp2(16, 5'd26, 1); tick();
        fin(3, 15); tick();
        check("inv_fin_num", 32'(com_inst_num_o), 32'd1);

        // Stall blocks dispatch but not retirement
        stall_dp_i = 1;
        dp1_i = 1; dp1_rrftag_i = 6'd20; dp1_dstnum_i = 5'd1; dp1_dst_we_i = 1;
        tick();
        stall_dp_i = 0;
        check("stall_comptr", 32'(comptr_o), 32'd16);
        fin(0, 20); fin(1, 16); tick();
        check("stall_num", 32'(com_inst_num_o), 32'd1);
        check("stall_tag", 32'(com1_rrftag_o), 32'd16);
        tick();
        check("stall_comptr_end", 32'(comptr_o), 32'd17);
        check("stall_empty", 32'(empty_o), 32'd1);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- In-order retirement stage directly downstream of the rename unit.
- Tracks every renamed instruction in a circular buffer indexed by its RRF tag.
- Collects completion from the five execution units and retires up to 2 instructions per cycle in program order.
- Drives the rename unit's commit inputs: com_inst_num to RRF entry allocation, and completed dst num/we/rrftag to the ARF/RRF write-back.

Parameters:
- RRF_NUM, 64, number of ROB/RRF entries; power of two.
- RRF_SEL, 6, log2(RRF_NUM); tag width.
- REG_SEL, 5, architectural register index width.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset, asynchronous, active-high
- stall_dp_i  in  1  dispatch stalled; suppresses all allocation this cycle
- dp1_i  in  1  dispatch slot 1 valid
- dp1_rrftag_i  in  RRF_SEL  tag allocated to slot 1 (rename rrfptr)
- dp1_dstnum_i  in  REG_SEL  slot 1 architectural destination
- dp1_dst_we_i  in  1  slot 1 writes a register
- dp2_i, dp2_rrftag_i, dp2_dstnum_i, dp2_dst_we_i  in  1/RRF_SEL/REG_SEL/1  same fields for slot 2
- fin_alu1_i, fin_alu2_i, fin_ldst_i, fin_mul_i, fin_branch_i  in  1 each  unit finished
- fin_alu1_rrftag_i ... fin_branch_rrftag_i  in  RRF_SEL each  finished tag
- comptr_o  out  RRF_SEL  oldest un-retired tag
- com_inst_num_o  out  2  instructions retired this cycle (0..2)
- com1_we_o, com1_dstnum_o, com1_rrftag_o  out  1/REG_SEL/RRF_SEL  retire slot 1 ARF update
- com2_we_o, com2_dstnum_o, com2_rrftag_o  out  1/REG_SEL/RRF_SEL  retire slot 2 ARF update
- empty_o  out  1  no valid entries

Behaviour:
- Reset (async assert): all valid and finished bits cleared, comptr_o=0, empty_o=1. Combinational commit outputs are 0 while reset is held. Reset mid-operation discards every in-flight entry.
- Per-entry state: valid, finished, dst_we, dstnum.
- Dispatch, on posedge when !stall_dp_i:
  - dpN_i sets valid=1 and finished=0 at dpN_rrftag_i, and latches dstnum/dst_we.
  - Slot 2 is accepted only together with slot 1. dp2 without dp1 is ignored; the bench flags it as an error.
- Finish, on posedge: each fin_X_i sets finished=1 at its tag.
  - Up to 5 simultaneous finishes, all to distinct tags.
  - A finish to an invalid entry is ignored.
  - Finish wins over a same-cycle dispatch to the same tag: it cannot legally occur, and dispatch clears finished.
- Commit is combinational from registered state:
  - c1 = valid[comptr] & finished[comptr].
  - c2 = c1 & valid[comptr+1] & finished[comptr+1], index modulo RRF_NUM.
  - com_inst_num_o = c1 + c2.
  - comN_we_o = cN & dst_we of that entry; dstnum/rrftag come from the entry.
  - When cN=0, comN_dstnum_o and comN_rrftag_o are 0.
- On posedge, committed entries clear valid/finished and comptr advances by com_inst_num_o, wrapping modulo RRF_NUM.
- Latency: a finish at edge N makes the entry retirable in cycle N; it is visible at comN outputs after edge N, and retired state updates at edge N+1. Dispatch-to-earliest-commit is 2 edges.
- Wrap-around: an entry at RRF_NUM-1 pairs with entry 0 as slot 2.
- Full: overrun is prevented upstream by the rename unit's allocatable/freenum signals. The ROB does not check occupancy. Same-cycle retire of tag T and dispatch to T is legal only when T was retired the previous cycle, so it never collides.
- Simultaneous dispatch, finish and commit on different tags all take effect in the same edge.
- Commit outputs ignore stall_dp_i; retirement continues during stalls.
- empty_o = no valid bits set (registered popcount not required; OR-reduce).

Decomposition:
- Shared constants header, already used by the core: RRF_NUM, RRF_SEL, REG_SEL, DATA_LEN.
- No new typedefs.
- One natural sub-module, rob_commit_select: combinational c1/c2/com_inst_num/output muxing from comptr and the entry arrays.
- Entry arrays and pointers stay in reorder_buffer.

Test Plan:
- Reset during activity: fill tags 0–5, assert reset_i mid-cycle -> outputs clear immediately, comptr_o=0, empty_o=1, no retirement of old tags after release.
- Dual dispatch at tags 0,1 (dst x3 we=1, dst x4 we=1), finish tag 1 then tag 0 -> nothing retires until tag 0 finishes, then com_inst_num_o=2, com1 = (x3, tag 0), com2 = (x4, tag 1), comptr_o 0→2.
- Dispatch tag 2 with dst_we=0, finish it -> com_inst_num_o=1, com1_we_o=0, com1_rrftag_o=2, comptr_o 2→3.
- Wrap: comptr_o=63, tags 63 and 0 valid and finished -> com_inst_num_o=2, com2_rrftag_o=0, comptr_o→1.
- Five simultaneous finishes on tags 10–14 with comptr_o=10 -> retires 2/cycle for 3 cycles (2,2,1), comptr_o ends at 15.
- Stall: stall_dp_i=1 with dp1_i=1 at tag 20 -> entry stays invalid; an already-finished head still retires during the stall.
